kbd_scan_sequencer: RTL and testbench
=====================================

// Module: kbd_scan_sequencer
// PURPOSE
//  Sequences the PS/2 set-2 byte stream into key events for the AT->ASCII lookup (at2ascii).
//  Strips E0/F0/E1 prefixes and drives the lookup code and live shift state.
//  Tags each event with release/extended flags and buffers events in a FIFO for the CPU side.
//  Sits between the PS/2 byte receiver and the keyboard I/O port.
// PARAMETERS
//  DEPTH      8       FIFO entries; power of 2, >=2
//  PAUSE_SKIP 7       bytes discarded after an E1 prefix (Pause/Break sequence)
//  TIMEOUT    250000  idle clocks in a prefix state before returning to IDLE (5 ms @ 50 MHz)
// PORTS
//  clock      in   1   system clock, all state on rising edge
//  reset_n    in   1   asynchronous active-low reset
//  kbd_hit    in   1   1-clock strobe: kbd_data holds a new received byte
//  kbd_data   in   8   received scan byte
//  at         out  8   registered scan code to at2ascii.at
//  shift      out  1   lshift|rshift, to at2ascii.shift
//  ascii_in   in   8   at2ascii.ascii (combinational return)
//  out_valid  out  1   FIFO not empty
//  out_ascii  out  8   head entry: translated code
//  out_rel    out  1   head entry: key released (F0 seen)
//  out_ext    out  1   head entry: E0-extended key
//  out_ack    in   1   pop head entry; ignored when out_valid=0
//  ovf        out  1   sticky: event or byte lost
//  ovf_clr    in   1   clears ovf; a same-cycle loss wins (ovf stays 1)
// BEHAVIOUR
//  Reset: state=IDLE, at=0, lshift=rshift=0, FIFO empty, ovf=0, all counters 0.
//   out_valid=0, out_ascii/out_rel/out_ext=0.
//  States: IDLE, PFX (prefix flags ext/rel held), SKIP (E1 swallow), LOOKUP.
//  IDLE/PFX on kbd_hit:
//   E0 -> ext=1, PFX.  F0 -> rel=1, PFX.
//   E1 (IDLE only) -> skip_cnt=PAUSE_SKIP, SKIP.
//   AA/FA/FE/EE/00/FF in IDLE -> ignored, stay IDLE.
//   E1 or ignored byte in PFX -> discard prefix, IDLE.
//   Other byte -> at<=byte, LOOKUP (ext/rel kept).
//  LOOKUP lasts exactly one clock. At its end:
//   - push {ext,rel,ascii_in}
//   - update shift: codes 12 (lshift) / 59 (rshift) set on make, clear on rel,
//     only when ext=0. E0 12 / E0 59 (fake shift) do not touch shift.
//   - clear ext/rel; state<=IDLE.
//  Latency: final byte on hit edge N -> entry visible, out_valid=1, after edge N+2.
//  kbd_hit during LOOKUP: byte dropped, ovf<=1.
//  SKIP: each kbd_hit decrements skip_cnt; leaving 0 -> IDLE. No entries pushed.
//  Timeout: in PFX or SKIP, a counter reloads on every kbd_hit.
//   TIMEOUT clocks with no hit -> clear ext/rel/skip, IDLE.
//  Shift events are themselves pushed (ascii 01). shift output changes the clock after the push.
//  FIFO: rd/wr pointers + count; out_* show head entry combinationally from storage.
//   Push when full and no pop: entry dropped, ovf<=1, contents unchanged.
//   Push+pop same clock when full: both happen, count stays DEPTH, no ovf.
//   Push+pop same clock when empty: push only. Pointers wrap modulo DEPTH.
//  Reset mid-sequence: everything returns to reset values at once. Partial prefix lost, no entry.
// TESTING
//  1C -> one entry {ext0,rel0,61}. Then 12,1C,F0 1C,F0 12:
//   entries 01(shift=1), 41, rel 41, rel 01. shift back to 0.
//  E0 75 -> {ext1,rel0,04}. E0 F0 75 -> {ext1,rel1,04}. Check out_valid rises 2 edges after last hit.
//  E0 12 E0 7C then 1C -> shift stays 0. Last entry is 61, not 41.
//  E1 14 77 E1 F0 14 F0 77, then 1C -> exactly one entry 61.
//  9x 1C with no ack (DEPTH 8) -> 8 entries, ovf=1.
//   Ack+push same clock when full -> count 8, order preserved. ovf_clr -> ovf=0.
//  E0, wait TIMEOUT clocks, 1C -> {ext0,61}.
//   F0 then reset_n pulse, then 1C -> {rel0,61}, FIFO held only that entry.

Source files
------------

// File: rtl/kbd_scan_sequencer.sv
// PS/2 set-2 byte sequencer: strips E0/F0/E1 prefixes, drives the at2ascii lookup
// and tracks the shift keys. Translated key events are queued in a FIFO for the CPU.
module kbd_scan_sequencer #(
    parameter int DEPTH      = 8,
    parameter int PAUSE_SKIP = 7,
    parameter int TIMEOUT    = 250000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       kbd_hit,
    input  logic [7:0] kbd_data,
    output logic [7:0] at,
    output logic       shift,
    input  logic [7:0] ascii_in,
    output logic       out_valid,
    output logic [7:0] out_ascii,
    output logic       out_rel,
    output logic       out_ext,
    input  logic       out_ack,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = (PAUSE_SKIP > 0) ? $clog2(PAUSE_SKIP + 1) : 1;

    localparam logic [AW:0]   L_FULL    = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] L_TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] L_SKIP    = SW'(PAUSE_SKIP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PFX,
        S_SKIP,
        S_LOOKUP
    } state_t;

    state_t        r_state;
    logic [7:0]    r_at;
    logic          r_ext;
    logic          r_rel;
    logic [SW-1:0] r_skip;
    logic [TW-1:0] r_to_cnt;

    logic          r_pend_vld;
    logic          r_pend_ext;
    logic          r_pend_rel;
    logic [7:0]    r_pend_asc;
    logic [7:0]    r_pend_at;

    logic          r_lshift;
    logic          r_rshift;
    logic          r_ovf;

    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;

    logic w_ign;
    logic w_to_hit;
    logic w_full;
    logic w_pop;
    logic w_wr;
    logic w_drop_evt;
    logic w_drop_byte;

    // Receiver status bytes that never start a key event.
    assign w_ign = kbd_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    assign w_to_hit = (r_to_cnt == L_TO_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_at       <= '0;
            r_ext      <= 1'b0;
            r_rel      <= 1'b0;
            r_skip     <= '0;
            r_to_cnt   <= '0;
            r_pend_vld <= 1'b0;
            r_pend_ext <= 1'b0;
            r_pend_rel <= 1'b0;
            r_pend_asc <= '0;
            r_pend_at  <= '0;
        end else begin
            r_pend_vld <= 1'b0;
            if (kbd_hit) begin
                r_to_cnt <= '0;
            end else if (r_state == S_PFX || r_state == S_SKIP) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (kbd_hit) begin
                        if (kbd_data == 8'hE0) begin
                            r_ext   <= 1'b1;
                            r_state <= S_PFX;
                        end else if (kbd_data == 8'hF0) begin
                            r_rel   <= 1'b1;
                            r_state <= S_PFX;
                        end else if (kbd_data == 8'hE1) begin
                            r_skip  <= L_SKIP;
                            r_state <= S_SKIP;
                        end else if (!w_ign) begin
                            r_at    <= kbd_data;
                            r_state <= S_LOOKUP;
                        end
                    end
                end
                S_PFX: begin
                    if (kbd_hit) begin
                        if (kbd_data == 8'hE0) begin
                            r_ext <= 1'b1;
                        end else if (kbd_data == 8'hF0) begin
                            r_rel <= 1'b1;
                        end else if (kbd_data == 8'hE1 || w_ign) begin
                            r_ext   <= 1'b0;
                            r_rel   <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_at    <= kbd_data;
                            r_state <= S_LOOKUP;
                        end
                    end else if (w_to_hit) begin
                        r_ext   <= 1'b0;
                        r_rel   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_SKIP: begin
                    if (kbd_hit) begin
                        if (r_skip == '0 || r_skip == SW'(1)) begin
                            r_skip  <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_skip <= r_skip - 1'b1;
                        end
                    end else if (w_to_hit) begin
                        r_skip  <= '0;
                        r_state <= S_IDLE;
                    end
                end
                S_LOOKUP: begin
                    // ascii_in is settled from r_at; capture it with the flags.
                    r_pend_vld <= 1'b1;
                    r_pend_ext <= r_ext;
                    r_pend_rel <= r_rel;
                    r_pend_asc <= ascii_in;
                    r_pend_at  <= r_at;
                    r_ext      <= 1'b0;
                    r_rel      <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_full      = (r_count == L_FULL);
    assign out_valid   = (r_count != '0);
    assign w_pop       = out_ack && out_valid;
    assign w_wr        = r_pend_vld && (!w_full || w_pop);
    assign w_drop_evt  = r_pend_vld && w_full && !w_pop;
    assign w_drop_byte = kbd_hit && (r_state == S_LOOKUP);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr     <= '0;
            r_rd     <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr] <= {r_pend_ext, r_pend_rel, r_pend_asc};
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            r_count <= r_count + (AW + 1)'(w_wr) - (AW + 1)'(w_pop);
            if (w_drop_evt || w_drop_byte) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
            // E0-prefixed 12/59 are fake shifts and leave the state alone.
            if (r_pend_vld && !r_pend_ext) begin
                if (r_pend_at == 8'h12) begin
                    r_lshift <= !r_pend_rel;
                end
                if (r_pend_at == 8'h59) begin
                    r_rshift <= !r_pend_rel;
                end
            end
        end
    end

    assign {out_ext, out_rel, out_ascii} = r_mem[r_rd];
    assign at    = r_at;
    assign shift = r_lshift | r_rshift;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_kbd_scan_sequencer.sv
// Bench for kbd_scan_sequencer: byte-stream vector table plus hand sequences
// for latency, overflow, timeout and reset; entries are checked from a scoreboard.
module tb_kbd_scan_sequencer;

    localparam int TO = 20;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       kbd_hit = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic [7:0] at;
    logic       shift;
    logic [7:0] ascii_in;
    logic       out_valid;
    logic [7:0] out_ascii;
    logic       out_rel;
    logic       out_ext;
    logic       out_ack = 1'b0;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    kbd_scan_sequencer #(
        .DEPTH(8),
        .PAUSE_SKIP(7),
        .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .kbd_hit(kbd_hit),
        .kbd_data(kbd_data),
        .at(at),
        .shift(shift),
        .ascii_in(ascii_in),
        .out_valid(out_valid),
        .out_ascii(out_ascii),
        .out_rel(out_rel),
        .out_ext(out_ext),
        .out_ack(out_ack),
        .ovf(ovf),
        .ovf_clr(ovf_clr)
    );

    always #5 clock = ~clock;

    // Small stand-in for the at2ascii lookup table.
    function automatic logic [7:0] at2ascii(input logic [7:0] code, input logic sh);
        case (code)
            8'h1C:        return sh ? 8'h41 : 8'h61;
            8'h12, 8'h59: return 8'h01;
            8'h75:        return 8'h04;
            8'h7C:        return 8'h2A;
            default:      return 8'h00;
        endcase
    endfunction

    assign ascii_in = at2ascii(at, shift);

    typedef struct {
        logic [7:0] d;
        logic       push;
        logic [9:0] ent;
        logic       dr;
        logic       sh;
    } vec_t;

    vec_t       tbl[$];
    logic [9:0] sb[$];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic [7:0] d, input logic push,
                                input logic [9:0] ent, input logic dr, input logic sh);
        vec_t v;
        v.d = d; v.push = push; v.ent = ent; v.dr = dr; v.sh = sh;
        tbl.push_back(v);
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        kbd_data = b;
        kbd_hit  = 1'b1;
        @(negedge clock);
        kbd_hit  = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic drain(input string nm);
        logic [9:0] e;
        repeat (3) @(negedge clock);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (!out_valid) begin
                chk({nm, "_missing"}, 32'(out_valid), 32'd1);
                sb.delete();
                break;
            end
            chk(nm, 32'({out_ext, out_rel, out_ascii}), 32'(e));
            out_ack = 1'b1;
            @(negedge clock);
            out_ack = 1'b0;
        end
        chk({nm, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] e;

        add(8'h1C, 1, 10'h061, 1, 0);
        add(8'h12, 1, 10'h001, 1, 1);
        add(8'h1C, 1, 10'h041, 1, 1);
        add(8'hF0, 0, 10'h000, 0, 1);
        add(8'h1C, 1, 10'h141, 1, 1);
        add(8'hF0, 0, 10'h000, 0, 1);
        add(8'h12, 1, 10'h101, 1, 0);
        add(8'hE0, 0, 10'h000, 0, 0);
        add(8'h75, 1, 10'h204, 1, 0);
        add(8'hE0, 0, 10'h000, 0, 0);
        add(8'hF0, 0, 10'h000, 0, 0);
        add(8'h75, 1, 10'h304, 1, 0);
        add(8'hE0, 0, 10'h000, 0, 0);
        add(8'h12, 1, 10'h201, 0, 0);
        add(8'hE0, 0, 10'h000, 0, 0);
        add(8'h7C, 1, 10'h22A, 0, 0);
        add(8'h1C, 1, 10'h061, 1, 0);
        add(8'hE1, 0, 10'h000, 0, 0);
        add(8'h14, 0, 10'h000, 0, 0);
        add(8'h77, 0, 10'h000, 0, 0);
        add(8'hE1, 0, 10'h000, 0, 0);
        add(8'hF0, 0, 10'h000, 0, 0);
        add(8'h14, 0, 10'h000, 0, 0);
        add(8'hF0, 0, 10'h000, 0, 0);
        add(8'h77, 0, 10'h000, 0, 0);
        add(8'h1C, 1, 10'h061, 1, 0);
        add(8'hAA, 0, 10'h000, 0, 0);
        add(8'hFA, 0, 10'h000, 0, 0);
        add(8'h1C, 1, 10'h061, 1, 0);
        add(8'hF0, 0, 10'h000, 0, 0);
        add(8'hAA, 0, 10'h000, 0, 0);
        add(8'h1C, 1, 10'h061, 1, 0);
        add(8'hE0, 0, 10'h000, 0, 0);
        add(8'hE1, 0, 10'h000, 0, 0);
        add(8'h1C, 1, 10'h061, 1, 0);
        add(8'h59, 1, 10'h001, 0, 1);
        add(8'h1C, 1, 10'h041, 0, 1);
        add(8'hF0, 0, 10'h000, 0, 1);
        add(8'h59, 1, 10'h101, 1, 0);

        repeat (3) @(negedge clock);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_at", 32'(at), 32'd0);
        chk("rst_shift", 32'(shift), 32'd0);
        chk("rst_head", 32'({out_ext, out_rel, out_ascii}), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        foreach (tbl[i]) begin
            send(tbl[i].d);
            if (tbl[i].push) sb.push_back(tbl[i].ent);
            if (tbl[i].dr) drain($sformatf("vec%0d", i));
            chk($sformatf("shift%0d", i), 32'(shift), 32'(tbl[i].sh));
        end

        // Final byte on edge N: entry visible only after edge N+2.
        @(negedge clock);
        kbd_data = 8'h1C;
        kbd_hit  = 1'b1;
        sb.push_back(10'h061);
        @(negedge clock);
        kbd_hit = 1'b0;
        chk("lat_n0", 32'(out_valid), 32'd0);
        @(negedge clock);
        chk("lat_n1", 32'(out_valid), 32'd0);
        @(negedge clock);
        chk("lat_n2", 32'(out_valid), 32'd1);
        drain("lat");

        for (int i = 0; i < 9; i++) begin
            send(8'h1C);
            if (i < 8) sb.push_back(10'h061);
        end
        chk("ovf_full", 32'(ovf), 32'd1);
        @(negedge clock); ovf_clr = 1'b1;
        @(negedge clock); ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);

        // Loss and clear on the same edge: loss wins.
        @(negedge clock); kbd_data = 8'h1C; kbd_hit = 1'b1;
        @(negedge clock); kbd_hit = 1'b0;
        @(negedge clock); ovf_clr = 1'b1;
        @(negedge clock); ovf_clr = 1'b0;
        chk("ovf_loss_wins", 32'(ovf), 32'd1);
        @(negedge clock); ovf_clr = 1'b1;
        @(negedge clock); ovf_clr = 1'b0;
        chk("ovf_clr2", 32'(ovf), 32'd0);

        // Pop lands on the same edge as a push into a full FIFO.
        @(negedge clock); kbd_data = 8'h75; kbd_hit = 1'b1;
        @(negedge clock); kbd_hit = 1'b0;
        @(negedge clock);
        e = sb.pop_front();
        chk("full_pp_head", 32'({out_ext, out_rel, out_ascii}), 32'(e));
        out_ack = 1'b1;
        @(negedge clock); out_ack = 1'b0;
        sb.push_back(10'h004);
        chk("full_pp_ovf", 32'(ovf), 32'd0);
        drain("full_pp");

        // Second hit arrives while the first is in lookup.
        @(negedge clock); kbd_data = 8'h1C; kbd_hit = 1'b1;
        @(negedge clock); kbd_data = 8'h75;
        @(negedge clock); kbd_hit = 1'b0;
        sb.push_back(10'h061);
        repeat (3) @(negedge clock);
        chk("lookup_drop_ovf", 32'(ovf), 32'd1);
        drain("lookup_drop");
        @(negedge clock); ovf_clr = 1'b1;
        @(negedge clock); ovf_clr = 1'b0;

        send(8'hE0);
        repeat (TO + 5) @(negedge clock);
        send(8'h1C);
        sb.push_back(10'h061);
        drain("to_pfx");

        send(8'hE0);
        repeat (TO - 8) @(negedge clock);
        send(8'hF0);
        repeat (TO - 8) @(negedge clock);
        send(8'h75);
        sb.push_back(10'h304);
        drain("to_reload");

        send(8'hE1);
        repeat (TO + 5) @(negedge clock);
        send(8'h1C);
        sb.push_back(10'h061);
        drain("to_skip");

        send(8'h1C);
        send(8'hF0);
        @(negedge clock); reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_at", 32'(at), 32'd0);
        reset_n = 1'b1;
        sb.delete();
        send(8'h1C);
        sb.push_back(10'h061);
        drain("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
